golden_nonce_tx: RTL and testbench

Downstream consumer of the hash core's golden-nonce strobe. Captures each 32-bit golden nonce presented with a one-cycle `golden_nonce_match` pulse into a small FIFO, then serialises queued nonces to the host over the UART transmit line as four 8N1 bytes, least-significant byte first. It decouples bursty matches from the slow serial link and flags any match lost to a full queue.

---
 rtl/golden_nonce_tx_pkg.sv | 20 ++
 rtl/golden_nonce_tx_nonce_fifo.sv | 77 +++++++
 rtl/golden_nonce_tx.sv | 159 +++++++++++++++
 tb/tb_golden_nonce_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/golden_nonce_tx_pkg.sv
// Shared definitions for the golden-nonce UART transmitter.
//   CLK_DIV_DEFAULT  : hash_clk cycles per UART bit (50 MHz / 115200)
//   BYTES_PER_NONCE  : bytes serialised per 32-bit nonce
//   BITS_PER_BYTE    : data bits per 8N1 character
//   tx_state_e       : UART framing FSM encoding
package golden_nonce_tx_pkg;

    localparam int CLK_DIV_DEFAULT = 434;
    localparam int NONCE_W         = 32;
    localparam int BYTES_PER_NONCE = 4;
    localparam int BITS_PER_BYTE   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/golden_nonce_tx_nonce_fifo.sv
// nonce_fifo: single-clock synchronous FIFO holding queued golden nonces.
//   clk, reset       : clock, synchronous active-high reset
//   push, push_data  : write request and data
//   pop              : read request; pop_data is the current head (show-ahead)
//   full, empty      : occupancy flags
//   count            : number of stored entries (0..2**DEPTH_LOG2)
// A push while full is accepted only if a pop happens in the same cycle.
module nonce_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/golden_nonce_tx.sv
// golden_nonce_tx: queues golden nonces and sends each to the host as four
// 8N1 UART bytes, least-significant byte first.
//   hash_clk           : sole clock
//   reset              : synchronous active-high reset
//   golden_nonce_in    : nonce, valid while golden_nonce_match is high
//   golden_nonce_match : one-cycle strobe per nonce
//   txd                : registered UART line, idle high
//   busy               : frame in progress (FSM not idle)
//   fifo_count         : nonces waiting, excluding the one being sent
//   overflow           : sticky, a nonce was dropped on a full queue
//
// state | meaning
// IDLE  | line high; pop next nonce when queue non-empty
// START | start bit (low) for CLK_DIV cycles
// DATA  | 8 data bits of current byte, LSB first
// STOP  | stop bit (high); next byte or back to IDLE
module golden_nonce_tx
    import golden_nonce_tx_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  hash_clk,
    input  logic                  reset,
    input  logic [31:0]           golden_nonce_in,
    input  logic                  golden_nonce_match,
    output logic                  txd,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);

    localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [2:0]  BIT_IDX_LAST  = 3'(BITS_PER_BYTE - 1);
    localparam logic [1:0]  BYTE_IDX_LAST = 2'(BYTES_PER_NONCE - 1);

    tx_state_e            state_q, state_d;
    logic [15:0]          bit_cnt_q, bit_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [NONCE_W-1:0]   shreg_q, shreg_d;
    logic                 txd_q, txd_d;
    logic                 overflow_q, overflow_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [NONCE_W-1:0]   fifo_head;
    logic                 bit_tc;

    // A pop in the same cycle frees a slot, so a strobe on a full queue
    // is only lost when the FSM is not popping.
    assign fifo_push = golden_nonce_match && (!fifo_full || fifo_pop);

    nonce_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (NONCE_W)
    ) u_fifo (
        .clk        (hash_clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (golden_nonce_in),
        .pop        (fifo_pop),
        .pop_data   (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign bit_tc   = (bit_cnt_q == BIT_LAST);
    assign txd      = txd_q;
    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        fifo_pop   = 1'b0;
        txd_d      = 1'b1;

        if (state_q != ST_IDLE) begin
            bit_cnt_d = bit_tc ? 16'd0 : bit_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_d    = fifo_head;
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                    bit_cnt_d  = 16'd0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_tc) begin
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tc) begin
                    if (bit_idx_q == BIT_IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tc) begin
                    if (byte_idx_q != BYTE_IDX_LAST) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        shreg_d    = shreg_q >> BITS_PER_BYTE;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // txd is registered, so it is derived from the state being entered.
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shreg_d[{2'b00, bit_idx_d}];
            default:  txd_d = 1'b1;
        endcase

        overflow_d = overflow_q | (golden_nonce_match && fifo_full && !fifo_pop);
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Testbench for golden_nonce_tx: directed scenarios plus random strobe
// traffic, compared every cycle against a frame-timing reference model.
module tb_golden_nonce_tx;

    localparam int CLK_DIV    = 4;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int FRAME      = 40 * CLK_DIV;
    localparam int GAP        = FRAME + 1;

    logic                 hash_clk = 1'b0;
    logic                 reset    = 1'b1;
    logic [31:0]          golden_nonce_in = '0;
    logic                 golden_nonce_match = 1'b0;
    logic                 txd;
    logic                 busy;
    logic [DEPTH_LOG2:0]  fifo_count;
    logic                 overflow;

    always #5 hash_clk = ~hash_clk;

    golden_nonce_tx #(
        .CLK_DIV    (CLK_DIV),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .hash_clk           (hash_clk),
        .reset              (reset),
        .golden_nonce_in    (golden_nonce_in),
        .golden_nonce_match (golden_nonce_match),
        .txd                (txd),
        .busy               (busy),
        .fifo_count         (fifo_count),
        .overflow           (overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue contents, the nonce on the line and the edge it
    // was popped at; line level follows from the frame arithmetic.
    logic [31:0] mq[$];
    int          cyc = 0;
    int          next_pop_ok = 0;
    int          tx_e = 0;
    bit          tx_valid = 0;
    logic [31:0] tx_nonce = '0;
    bit          ovf_m = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit in_frame();
        int o;
        o = cyc - tx_e - 1;
        return tx_valid && (o >= 0) && (o < FRAME);
    endfunction

    function automatic logic exp_txd();
        int o, byte_i, slot;
        if (!in_frame()) return 1'b1;
        o      = cyc - tx_e - 1;
        byte_i = o / 40 / 1;
        byte_i = o / (10 * CLK_DIV);
        slot   = (o % (10 * CLK_DIV)) / CLK_DIV;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return tx_nonce[byte_i * 8 + slot - 1];
    endfunction

    task automatic model_edge(input bit r, input bit m, input logic [31:0] n);
        bit pop, full;
        if (r) begin
            mq.delete();
            ovf_m       = 0;
            tx_valid    = 0;
            next_pop_ok = cyc + 1;
            cyc++;
            return;
        end
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && (cyc >= next_pop_ok);
        if (pop) begin
            tx_nonce    = mq.pop_front();
            tx_e        = cyc;
            tx_valid    = 1;
            next_pop_ok = cyc + GAP;
        end
        if (m) begin
            if (!full || pop) mq.push_back(n);
            else ovf_m = 1;
        end
        cyc++;
    endtask

    task automatic check_outputs();
        check_val("txd",        32'(txd),        32'(exp_txd()));
        check_val("busy",       32'(busy),       32'(in_frame()));
        check_val("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check_val("overflow",   32'(overflow),   32'(ovf_m));
    endtask

    // Drive at the falling edge, let the rising edge act, check at the next
    // falling edge.
    task automatic cycle(input bit r, input bit m, input logic [31:0] n);
        reset              = r;
        golden_nonce_match = m;
        golden_nonce_in    = n;
        @(posedge hash_clk);
        model_edge(r, m, n);
        @(negedge hash_clk);
        check_outputs();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int dens;
        repeat (3) @(posedge hash_clk);
        @(negedge hash_clk);
        check_outputs();
        cycle(1'b1, 1'b0, 32'h0);

        // single nonce
        cycle(1'b0, 1'b1, 32'h1234_5678);
        check_val("single_cnt", 32'(fifo_count), 32'd1);
        cycle(1'b0, 1'b0, 32'h0);
        check_val("single_txd_fall", 32'(txd), 32'd0);
        check_val("single_busy", 32'(busy), 32'd1);
        idle(FRAME + 5);
        check_val("single_done", 32'(busy), 32'd0);

        // five strobes, four queued behind the first
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 32'(i));
        check_val("five_cnt", 32'(fifo_count), 32'd4);
        idle(5 * GAP + 5);
        check_val("five_ovf", 32'(overflow), 32'd0);

        // six strobes: the sixth is dropped
        for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, 32'(i));
        check_val("six_ovf", 32'(overflow), 32'd1);
        idle(5 * GAP + 5);
        check_val("six_ovf_held", 32'(overflow), 32'd1);
        cycle(1'b1, 1'b0, 32'h0);
        check_val("six_ovf_clr", 32'(overflow), 32'd0);

        // strobe into a full queue on the pop edge
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'hA000_0000 + 32'(i));
        while (cyc != next_pop_ok) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hF00D_0006);
        check_val("fpop_cnt", 32'(fifo_count), 32'd4);
        check_val("fpop_ovf", 32'(overflow), 32'd0);
        idle(6 * GAP);

        // reset during DATA of byte 2 with two queued
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hC0DE_0000 + 32'(i));
        while (cyc < tx_e + 1 + 2 * 10 * CLK_DIV + 2 * CLK_DIV) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check_val("rst_txd",  32'(txd),        32'd1);
        check_val("rst_busy", 32'(busy),       32'd0);
        check_val("rst_cnt",  32'(fifo_count), 32'd0);
        idle(2 * GAP);

        // random traffic with varying burst density
        dens = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       dens = 2;
                    1:       dens = 30;
                    default: dens = 90;
                endcase
            end
            cycle($urandom_range(0, 1499) == 0,
                  $urandom_range(0, 99) < dens,
                  $urandom);
        end
        idle(DEPTH * GAP + GAP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
